// File: rtl/multi_line_input_conditioner.sv
// Per-channel input conditioning for asynchronous serial/control lines:
// 2-flop sync, stable-count glitch filter, edge strobes and stretched activity pulses.
module multi_line_input_conditioner #(
    parameter int   CHANNELS    = 4,
    parameter int   FILTER_LEN  = 4,
    parameter int   STRETCH_LEN = 8,
    parameter logic IDLE_LEVEL  = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] TX,
    input  logic [CHANNELS-1:0] EN,
    input  logic                HIGH,
    output logic [CHANNELS-1:0] TX_OUT,
    output logic [CHANNELS-1:0] RISE,
    output logic [CHANNELS-1:0] FALL,
    output logic [CHANNELS-1:0] PULSE
);

    localparam int MAX_LEN = (FILTER_LEN > STRETCH_LEN) ? FILTER_LEN : STRETCH_LEN;
    localparam int CW      = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] FILT_LAST    = CW'(FILTER_LEN - 1);
    localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH_LEN);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic          r_s1;
            logic          r_s2;
            logic          r_stable;
            logic          r_rise;
            logic          r_fall;
            logic          r_pulse;
            logic [CW-1:0] r_filt_cnt;
            logic [CW-1:0] r_str_cnt;
            logic          w_strobe;

            assign w_strobe = r_rise | r_fall;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_s1       <= IDLE_LEVEL;
                    r_s2       <= IDLE_LEVEL;
                    r_stable   <= IDLE_LEVEL;
                    r_rise     <= 1'b0;
                    r_fall     <= 1'b0;
                    r_pulse    <= 1'b0;
                    r_filt_cnt <= '0;
                    r_str_cnt  <= '0;
                end else begin
                    r_s1   <= TX[gi];
                    r_s2   <= r_s1;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;

                    // Disabling or a matching sample discards any pending count.
                    if (!EN[gi] || (r_s2 == r_stable)) begin
                        r_filt_cnt <= '0;
                    end else if (r_filt_cnt == FILT_LAST) begin
                        r_filt_cnt <= '0;
                        r_stable   <= r_s2;
                        r_rise     <= r_s2;
                        r_fall     <= ~r_s2;
                    end else begin
                        r_filt_cnt <= r_filt_cnt + CNT_ONE;
                    end

                    if (w_strobe) begin
                        r_str_cnt <= STRETCH_LOAD;
                        r_pulse   <= 1'b1;
                    end else if (r_str_cnt != '0) begin
                        r_str_cnt <= r_str_cnt - CNT_ONE;
                        r_pulse   <= (r_str_cnt != CNT_ONE);
                    end else begin
                        r_pulse   <= 1'b0;
                    end
                end
            end

            assign TX_OUT[gi] = r_stable ^ ~HIGH;
            assign RISE[gi]   = r_rise;
            assign FALL[gi]   = r_fall;
            assign PULSE[gi]  = r_pulse;
        end
    endgenerate

endmodule

// File: tb/tb_multi_line_input_conditioner.sv
// Bench for multi_line_input_conditioner: directed scenarios plus random traffic,
// all checked against a windowed behavioural model of accepted line edges.
module tb_multi_line_input_conditioner;

    localparam int   C    = 4;
    localparam int   F    = 4;
    localparam int   S    = 8;
    localparam logic IDLE = 1'b1;
    localparam int   MAXE = 8192;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         HIGH = 1'b1;
    logic [C-1:0] TX = '1;
    logic [C-1:0] EN = '1;
    logic [C-1:0] TX_OUT, RISE, FALL, PULSE;

    int n_tests = 0;
    int n_fail  = 0;

    multi_line_input_conditioner #(
        .CHANNELS(C), .FILTER_LEN(F), .STRETCH_LEN(S), .IDLE_LEVEL(IDLE)
    ) dut (
        .CLK(CLK), .RST(RST), .TX(TX), .EN(EN), .HIGH(HIGH),
        .TX_OUT(TX_OUT), .RISE(RISE), .FALL(FALL), .PULSE(PULSE)
    );

    always #20 CLK = ~CLK;

    // Model: an edge is accepted at clock edge n when the previous F edges all had
    // EN set, all saw a synchronised sample (TX from two edges earlier) differing
    // from the accepted level, and no acceptance happened inside that window.
    logic [C-1:0] txs [MAXE];
    logic [C-1:0] enh [MAXE];
    int           ne;
    int           last_acc [C];
    logic [C-1:0] m_stable, m_rise, m_fall, m_pulse;

    initial begin : model
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                ne       = 0;
                m_stable = {C{IDLE}};
                m_rise   = '0;
                m_fall   = '0;
                m_pulse  = '0;
                for (int c = 0; c < C; c++) last_acc[c] = -1000;
            end else begin
                if (ne < MAXE) begin
                    txs[ne] = TX;
                    enh[ne] = EN;
                end
                for (int c = 0; c < C; c++) begin
                    bit acc;
                    acc = (last_acc[c] <= ne - F);
                    for (int j = 0; j < F; j++) begin
                        int   e;
                        logic smp;
                        e = ne - j;
                        if (e < 0 || e >= MAXE) begin
                            acc = 1'b0;
                        end else begin
                            smp = (e >= 2) ? txs[e-2][c] : IDLE;
                            if (!enh[e][c] || smp == m_stable[c]) acc = 1'b0;
                        end
                    end
                    m_pulse[c] = (ne - last_acc[c] >= 1) && (ne - last_acc[c] <= S);
                    m_rise[c]  = 1'b0;
                    m_fall[c]  = 1'b0;
                    if (acc) begin
                        m_rise[c]   = ~m_stable[c];
                        m_fall[c]   = m_stable[c];
                        m_stable[c] = ~m_stable[c];
                        last_acc[c] = ne;
                    end
                end
                ne++;
            end
        end
    end

    function automatic logic [4*C-1:0] exp_vec();
        return {m_stable ^ {C{~HIGH}}, m_rise, m_fall, m_pulse};
    endfunction

    task automatic test_reset();
        RST = 1'b1; TX = 4'hF; EN = 4'hF; HIGH = 1'b1;
        repeat (3) @(negedge CLK);
        n_tests++;
        if ({TX_OUT, RISE, FALL, PULSE} !== 16'hF000) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", {TX_OUT, RISE, FALL, PULSE}, 16'hF000);
        end
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            n_tests++;
            if ({TX_OUT, RISE, FALL, PULSE} !== 16'hF000 || {TX_OUT, RISE, FALL, PULSE} !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_release cyc %0d: got %h expected %h", i, {TX_OUT, RISE, FALL, PULSE}, 16'hF000);
            end
        end
        $display("[TB] reset: outputs idle for 20 cycles after release");
    endtask

    task automatic test_glitch();
        TX[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            n_tests++;
            if ({TX_OUT, RISE, FALL, PULSE} !== exp_vec() || FALL[0] !== 1'b0 || TX_OUT[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL glitch cyc %0d: got %h expected %h", i, {TX_OUT, RISE, FALL, PULSE}, exp_vec());
            end
            if (i == 2) TX[0] = 1'b1;
        end
        $display("[TB] glitch: 3-sample low excursion on ch0 rejected");
    endtask

    task automatic test_clean_edge();
        TX[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            n_tests++;
            if ({TX_OUT, RISE, FALL, PULSE} !== exp_vec() || FALL[0] !== (i == 5) ||
                PULSE[0] !== (i >= 6 && i <= 13) || (i >= 5 && TX_OUT[0] !== 1'b0)) begin
                n_fail++;
                $display("FAIL clean_edge cyc %0d: got %h expected %h", i, {TX_OUT, RISE, FALL, PULSE}, exp_vec());
            end
        end
        $display("[TB] clean edge: FALL[0] at edge 5, PULSE[0] edges 6..13");
    endtask

    task automatic test_retrigger();
        TX[0] = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge CLK);
            n_tests++;
            if ({TX_OUT, RISE, FALL, PULSE} !== exp_vec() || RISE[0] !== (i == 5) ||
                FALL[0] !== (i == 11) || PULSE[0] !== (i >= 6 && i <= 19)) begin
                n_fail++;
                $display("FAIL retrigger cyc %0d: got %h expected %h", i, {TX_OUT, RISE, FALL, PULSE}, exp_vec());
            end
            if (i == 5) TX[0] = 1'b0;
        end
        $display("[TB] retrigger: PULSE[0] continuous across RISE and FALL");
    endtask

    task automatic test_multi_channel();
        TX[3:2] = 2'b00;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            n_tests++;
            if ({TX_OUT, RISE, FALL, PULSE} !== exp_vec() || FALL[3:2] !== ((i == 5) ? 2'b11 : 2'b00) ||
                RISE[3:2] !== ((i == 13) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL multi_channel cyc %0d: got %h expected %h", i, {TX_OUT, RISE, FALL, PULSE}, exp_vec());
            end
            if (i == 7) TX[3:2] = 2'b11;
        end
        $display("[TB] multi-channel: ch3/ch2 strobes reported together");
    endtask

    task automatic test_enable_polarity();
        EN[1] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            n_tests++;
            if ({TX_OUT, RISE, FALL, PULSE} !== exp_vec() || RISE[1] !== 1'b0 ||
                FALL[1] !== 1'b0 || TX_OUT[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL enable_off cyc %0d: got %h expected %h", i, {TX_OUT, RISE, FALL, PULSE}, exp_vec());
            end
            TX[1] = (i < 11) ? ~TX[1] : 1'b0;
        end
        EN[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            n_tests++;
            if ({TX_OUT, RISE, FALL, PULSE} !== exp_vec() || FALL[1] !== (i == 3)) begin
                n_fail++;
                $display("FAIL enable_on cyc %0d: got %h expected %h", i, {TX_OUT, RISE, FALL, PULSE}, exp_vec());
            end
        end
        @(negedge CLK);
        #5 HIGH = 1'b0;
        #1;
        n_tests++;
        if (TX_OUT !== 4'b0011 || {TX_OUT, RISE, FALL, PULSE} !== exp_vec()) begin
            n_fail++;
            $display("FAIL polarity_low: got %h expected %h", TX_OUT, 4'b0011);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            n_tests++;
            if ({TX_OUT, RISE, FALL, PULSE} !== exp_vec() || (RISE | FALL) !== 4'b0000) begin
                n_fail++;
                $display("FAIL polarity_hold cyc %0d: got %h expected %h", i, {TX_OUT, RISE, FALL, PULSE}, exp_vec());
            end
        end
        HIGH = 1'b1;
        #1;
        n_tests++;
        if (TX_OUT !== 4'b1100) begin
            n_fail++;
            $display("FAIL polarity_high: got %h expected %h", TX_OUT, 4'b1100);
        end
        $display("[TB] enable/polarity: ch1 frozen while disabled, HIGH inverts TX_OUT");
    endtask

    task automatic test_reset_mid_filter();
        TX = 4'b1111;
        repeat (12) @(negedge CLK);
        TX[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            n_tests++;
            if ({TX_OUT, RISE, FALL, PULSE} !== exp_vec()) begin
                n_fail++;
                $display("FAIL pre_reset cyc %0d: got %h expected %h", i, {TX_OUT, RISE, FALL, PULSE}, exp_vec());
            end
        end
        #5 RST = 1'b1;
        #1;
        n_tests++;
        if ({TX_OUT, RISE, FALL, PULSE} !== 16'hF000 || {TX_OUT, RISE, FALL, PULSE} !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", {TX_OUT, RISE, FALL, PULSE}, 16'hF000);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge CLK);
            n_tests++;
            if ({TX_OUT, RISE, FALL, PULSE} !== exp_vec() || FALL[2] !== (j == 5)) begin
                n_fail++;
                $display("FAIL post_reset cyc %0d: got %h expected %h", j, {TX_OUT, RISE, FALL, PULSE}, exp_vec());
            end
        end
        $display("[TB] reset mid-filter: FALL[2] needs full delay after release");
    endtask

    task automatic test_random();
        int strobes;
        strobes = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge CLK);
            n_tests++;
            if ({TX_OUT, RISE, FALL, PULSE} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h expected %h", i, {TX_OUT, RISE, FALL, PULSE}, exp_vec());
            end
            strobes += $countones(RISE | FALL);
            for (int c = 0; c < C; c++) begin
                if ($urandom_range(5, 0) == 0) TX[c] = ~TX[c];
                if ($urandom_range(39, 0) == 0) EN[c] = ~EN[c];
            end
            if ($urandom_range(49, 0) == 0) HIGH = ~HIGH;
        end
        $display("[TB] random: 800 cycles, %0d strobes observed", strobes);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_clean_edge();
        test_retrigger();
        test_multi_channel();
        test_enable_polarity();
        test_reset_mid_filter();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
